// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
//   master : drives i_en, i_load, i_load_val, i_periodic, i_clear;
//            observes o_count, o_busy, o_done
//   slave  : the timer itself (the mirror image)
interface countdown_timer_if #(
  parameter int WIDTH = 12
);
  logic             i_en;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic             i_periodic;
  logic             i_clear;
  logic [WIDTH-1:0] o_count;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_en, i_load, i_load_val, i_periodic, i_clear,
    input  o_count, o_busy, o_done
  );

  modport slave (
    input  i_en, i_load, i_load_val, i_periodic, i_clear,
    output o_count, o_busy, o_done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter / timer.
// Loads a start value, decrements once per enabled clock while running and
// emits a one-cycle o_done pulse on expiry. One-shot mode stops at zero,
// periodic mode reloads the captured start value and keeps running.
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : synchronous reset, active-high
//   bus   : countdown_timer_if slave modport (enable, load, load value,
//           mode, clear in; count, busy, done out -- all outputs registered)
module countdown_timer #(
  parameter int WIDTH = 12
) (
  input logic               i_clk,
  input logic               i_rst,
  countdown_timer_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q,    state_d;
  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] reload_q,   reload_d;
  logic             periodic_q, periodic_d;
  logic             done_q,     done_d;
  logic             busy_q,     busy_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;

    if (bus.i_clear) begin
      // Abort keeps the captured reload value and mode.
      count_d = '0;
      state_d = IDLE;
    end else if (bus.i_load) begin
      count_d    = bus.i_load_val;
      reload_d   = bus.i_load_val;
      periodic_d = bus.i_periodic;
      if (bus.i_load_val == '0) begin
        // Zero load expires immediately and never enters RUN, so a periodic
        // reload of zero can never be reached.
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && bus.i_en) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        done_d = 1'b1;
        if (periodic_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      reload_q   <= '0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.o_count = count_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;
  localparam int WIDTH = 12;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  countdown_timer_if #(.WIDTH(WIDTH)) bus ();

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Reference model: timer described as "remaining ticks" plus running flag.
  int m_count = 0;
  int m_reload = 0;
  bit m_per = 1'b0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;

  always @(posedge i_clk) begin
    if (i_rst) begin
      m_count = 0; m_reload = 0; m_per = 1'b0; m_run = 1'b0; m_done = 1'b0;
    end else if (bus.i_clear) begin
      m_count = 0; m_run = 1'b0; m_done = 1'b0;
    end else if (bus.i_load) begin
      m_count  = int'(bus.i_load_val);
      m_reload = m_count;
      m_per    = bus.i_periodic;
      m_run    = (m_count != 0);
      m_done   = (m_count == 0);
    end else if (m_run && bus.i_en) begin
      if (m_count == 1) begin
        m_done  = 1'b1;
        m_count = m_per ? m_reload : 0;
        m_run   = m_per;
      end else begin
        m_done  = 1'b0;
        m_count = m_count - 1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      check("model_count", int'(bus.o_count), m_count);
      check("model_busy",  int'(bus.o_busy),  int'(m_run));
      check("model_done",  int'(bus.o_done),  int'(m_done));
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_load(input int val, input bit per);
    bus.i_load     = 1'b1;
    bus.i_load_val = WIDTH'(val);
    bus.i_periodic = per;
    step();
    bus.i_load     = 1'b0;
  endtask

  int first_done;
  int n_done;
  int busy_low;

  initial begin
    bus.i_en = 1'b0; bus.i_load = 1'b0; bus.i_load_val = '0;
    bus.i_periodic = 1'b0; bus.i_clear = 1'b0;

    // 1: reset, one-shot 10
    i_rst = 1'b1;
    step();
    chk_en = 1'b1;
    repeat (15) step();
    check("reset_count", int'(bus.o_count), 0);
    check("reset_busy",  int'(bus.o_busy),  0);
    check("reset_done",  int'(bus.o_done),  0);
    i_rst = 1'b0;
    bus.i_en = 1'b1;
    do_load(10, 1'b0);
    first_done = 0; n_done = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.o_done) begin
        n_done++;
        if (first_done == 0) first_done = k;
      end
    end
    check("t1_done_pulses", n_done, 1);
    check("t1_done_edge",   first_done, 10);
    check("t1_count_after", int'(bus.o_count), 0);
    check("t1_busy_after",  int'(bus.o_busy), 0);

    // 2: pause
    do_load(5, 1'b0);
    repeat (2) step();
    bus.i_en = 1'b0;
    n_done = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (bus.o_done) n_done++;
    end
    check("t2_hold_count", int'(bus.o_count), 3);
    check("t2_hold_busy",  int'(bus.o_busy), 1);
    check("t2_hold_nodone", n_done, 0);
    bus.i_en = 1'b1;
    first_done = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (bus.o_done && first_done == 0) first_done = k;
    end
    check("t2_resume_done_edge", first_done, 3);

    // 3: periodic 4
    do_load(4, 1'b1);
    n_done = 0; busy_low = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.o_done) n_done++;
      if (!bus.o_busy) busy_low++;
      if (k == 2) check("t3_count_k2", int'(bus.o_count), 2);
      if (k == 4) check("t3_count_reload", int'(bus.o_count), 4);
    end
    check("t3_pulses", n_done, 5);
    check("t3_busy_drops", busy_low, 0);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;

    // 4: clear mid-run
    do_load(10, 1'b0);
    repeat (3) step();
    check("t4_count_before_clear", int'(bus.o_count), 7);
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    check("t4_clear_count", int'(bus.o_count), 0);
    check("t4_clear_busy",  int'(bus.o_busy), 0);
    check("t4_clear_done",  int'(bus.o_done), 0);
    do_load(2, 1'b0);
    first_done = 0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (bus.o_done && first_done == 0) first_done = k;
    end
    check("t4_reload_done_edge", first_done, 2);

    // 5: load zero
    do_load(0, 1'b1);
    check("t5_done",  int'(bus.o_done), 1);
    check("t5_busy",  int'(bus.o_busy), 0);
    check("t5_count", int'(bus.o_count), 0);
    step();
    check("t5_done_gone", int'(bus.o_done), 0);

    // 6: periodic 1, reset mid-run
    do_load(1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_done_each", int'(bus.o_done), 1);
    end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("t6_rst_count", int'(bus.o_count), 0);
    check("t6_rst_busy",  int'(bus.o_busy), 0);
    check("t6_rst_done",  int'(bus.o_done), 0);
    // load at the expiry edge wins over the expiry
    do_load(1, 1'b0);
    do_load(6, 1'b0);
    check("t6_load_wins_done",  int'(bus.o_done), 0);
    check("t6_load_wins_count", int'(bus.o_count), 6);

    // clear beats a simultaneous load; IDLE ignores enable
    bus.i_clear = 1'b1;
    do_load(9, 1'b0);
    bus.i_clear = 1'b0;
    check("clr_load_count", int'(bus.o_count), 0);
    check("clr_load_busy",  int'(bus.o_busy), 0);
    repeat (3) step();
    check("idle_no_wrap", int'(bus.o_count), 0);

    bus.i_en = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
